// File: rtl/incrementador_pkg.sv
// rtl/incrementador_pkg.sv - shared types and defaults for the button-driven up-counter
package incrementador_pkg;

  // Debounce FSM states: waiting for press, qualifying press, held, qualifying release
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  localparam int N_DEFAULT               = 6;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int REPEAT_CYCLES_DEFAULT   = 8;

endpackage

// File: rtl/incrementador_boton_antirrebote.sv
// rtl/incrementador_boton_antirrebote.sv - button synchronizer + debounce FSM (auto-repeat under INCREMENTADOR_AUTOREPEAT_EN)
module antirrebote
  import incrementador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
`ifdef INCREMENTADOR_AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic inc_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1;
  logic          sync2;
  deb_state_t    state;
  logic [CW-1:0] cnt;
  logic          press_accept;

  // Two-flop synchronizer for the raw, asynchronous button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Debounce FSM: a level must be stable for DEBOUNCE_CYCLES synced cycles to be believed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sync2) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= PRESSED;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync2) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync2) begin
            state <= PRESSED;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // The accepting transition itself is the pulse, so the counter moves on the same edge the FSM enters PRESSED
  assign press_accept = (state == PRESS_WAIT) && sync2 && (cnt == CNT_LAST);

`ifdef INCREMENTADOR_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] REP_ONE  = RW'(1);

  logic [RW-1:0] rep_cnt;
  logic          repeat_fire;

  // Repeat timer runs only while held in PRESSED; it is zero on entry and cleared on exit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt <= '0;
    end else if ((state == PRESSED) && sync2) begin
      if (rep_cnt == REP_LAST) begin
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + REP_ONE;
      end
    end else begin
      rep_cnt <= '0;
    end
  end

  assign repeat_fire = (state == PRESSED) && sync2 && (rep_cnt == REP_LAST);
  assign inc_pulse   = press_accept | repeat_fire;
`else
  assign inc_pulse = press_accept;
`endif

endmodule

// File: rtl/incrementador_boton.sv
// rtl/incrementador_boton.sv - debounced button up-counter with switch load (optional auto-repeat via INCREMENTADOR_AUTOREPEAT_EN)
module incrementador_boton
  import incrementador_pkg::*;
#(
  parameter int N               = N_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit WRAP            = 1'b1
`ifdef INCREMENTADOR_AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         btn_add,
  input  logic         btn_load,
  input  logic [N-1:0] data_in,
  output logic [N-1:0] data_out,
  output logic         ovf,
  output logic         at_max
);

  localparam logic [N-1:0] ONE = N'(1);

  logic inc_pulse;
  logic load_sync1;
  logic load_sync2;
  logic load_prev;
  logic load_edge;

  antirrebote #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef INCREMENTADOR_AUTOREPEAT_EN
    ,
    .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
  ) u_antirrebote (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn_add),
    .inc_pulse (inc_pulse)
  );

  // Load button: two-flop synchronizer plus one history flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_sync1 <= 1'b0;
      load_sync2 <= 1'b0;
      load_prev  <= 1'b0;
    end else begin
      load_sync1 <= btn_load;
      load_sync2 <= load_sync1;
      load_prev  <= load_sync2;
    end
  end

  assign load_edge = load_sync2 & ~load_prev;
  assign at_max    = &data_out;

  // Counter register: load has priority and swallows a coincident increment; ovf flags increments taken at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      ovf      <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (load_edge) begin
        data_out <= data_in;
      end else if (inc_pulse) begin
        if (at_max) begin
          ovf <= 1'b1;
          if (WRAP) begin
            data_out <= '0;
          end
        end else begin
          data_out <= data_out + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_incrementador_boton.sv
// tb/tb_incrementador_boton.sv - directed self-checking bench for incrementador_boton
module tb_incrementador_boton;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_add;
  logic       btn_load;
  logic [5:0] data_in;
  logic [5:0] data_out;
  logic       ovf;
  logic       at_max;
  logic [5:0] data_out_s;
  logic       ovf_s;
  logic       at_max_s;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  incrementador_boton #(.N(6), .DEBOUNCE_CYCLES(4), .WRAP(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_add  (btn_add),
    .btn_load (btn_load),
    .data_in  (data_in),
    .data_out (data_out),
    .ovf      (ovf),
    .at_max   (at_max)
  );

  incrementador_boton #(.N(6), .DEBOUNCE_CYCLES(4), .WRAP(1'b0)) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .btn_add  (btn_add),
    .btn_load (btn_load),
    .data_in  (data_in),
    .data_out (data_out_s),
    .ovf      (ovf_s),
    .at_max   (at_max_s)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [5:0] v);
    data_in  = v;
    btn_load = 1'b1;
    tick(4);
    btn_load = 1'b0;
    tick(3);
  endtask

  initial begin
    rst      = 1'b1;
    btn_add  = 1'b0;
    btn_load = 1'b0;
    data_in  = 6'd9;
    tick(2);
    check("reset_data_out", data_out, 0);
    check("reset_ovf", ovf, 0);
    check("reset_at_max", at_max, 0);
    rst = 1'b0;
    tick(1);
    check("post_reset_data_out", data_out, 0);

    btn_load = 1'b1;
    tick(4);
    check("load_9", data_out, 9);
    btn_load = 1'b0;
    tick(3);

    btn_add = 1'b1;
    tick(6);
    check("press_edge6_unchanged", data_out, 9);
    tick(1);
    check("press_edge7_incremented", data_out, 10);
    check("press_ovf_low", ovf, 0);
    tick(13);
`ifdef INCREMENTADOR_AUTOREPEAT_EN
    check("hold_20_repeat", data_out, 11);
`else
    check("hold_20_single_inc", data_out, 10);
`endif
    btn_add = 1'b0;
    tick(10);

    for (int i = 0; i < 4; i++) begin
      btn_add = 1'b1;
      tick(1);
      check("bounce_ovf", ovf, 0);
      tick(1);
      btn_add = 1'b0;
      tick(1);
      check("bounce_ovf", ovf, 0);
      tick(1);
    end
    tick(8);
`ifdef INCREMENTADOR_AUTOREPEAT_EN
    check("bounce_no_inc", data_out, 11);
`else
    check("bounce_no_inc", data_out, 10);
`endif

    do_load(6'd63);
    check("load_63_wrap", data_out, 63);
    check("load_63_sat", data_out_s, 63);
    check("at_max_wrap_before", at_max, 1);
    btn_add = 1'b1;
    tick(7);
    check("wrap_data_out", data_out, 0);
    check("wrap_ovf", ovf, 1);
    check("wrap_at_max", at_max, 0);
    check("sat_data_out", data_out_s, 63);
    check("sat_ovf", ovf_s, 1);
    check("sat_at_max", at_max_s, 1);
    tick(1);
    check("wrap_ovf_one_cycle", ovf, 0);
    check("sat_ovf_one_cycle", ovf_s, 0);
    btn_add = 1'b0;
    tick(10);
    check("sat_at_max_after", at_max_s, 1);
    check("sat_hold_after", data_out_s, 63);

    do_load(6'd20);
    check("load_20", data_out, 20);
    data_in = 6'd5;
    btn_add = 1'b1;
    tick(4);
    btn_load = 1'b1;
    tick(2);
    check("coincide_before", data_out, 20);
    tick(1);
    check("coincide_load_wins", data_out, 5);
    check("coincide_ovf", ovf, 0);
    tick(1);
    check("coincide_no_late_inc", data_out, 5);
    btn_add  = 1'b0;
    btn_load = 1'b0;
    tick(12);

    btn_add = 1'b1;
    tick(4);
    rst = 1'b1;
    #1;
    check("async_reset_data_out", data_out, 0);
    check("async_reset_ovf", ovf, 0);
    tick(2);
    rst = 1'b0;
    tick(6);
    check("reset_redebounce_wait", data_out, 0);
    tick(1);
    check("reset_redebounce_once", data_out, 1);
    btn_add = 1'b0;
    tick(10);
    check("reset_redebounce_final", data_out, 1);

`ifdef INCREMENTADOR_AUTOREPEAT_EN
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    btn_add = 1'b1;
    tick(6);
    check("rep_edge6", data_out, 0);
    tick(1);
    check("rep_edge7", data_out, 1);
    tick(7);
    check("rep_edge14", data_out, 1);
    tick(1);
    check("rep_edge15", data_out, 2);
    tick(24);
    check("rep_edge39", data_out, 5);
    btn_add = 1'b0;
    tick(10);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
